// File: rtl/gps_emu_pkg.sv
// Shared definitions for the GPS emulator scenario controller.
//   - Address-map constants (target select and field offsets)
//   - CA_SEL_MAX: highest legal C/A code select value
//   - state_e: scenario controller FSM states
//   - sat_cfg_t: per-satellite configuration record used for both the
//     shadow (host-writable) and active (emulator-facing) copies
//   - write_legal(): decides whether a host write hits a real register
//     with an acceptable value
package gps_emu_pkg;

  localparam logic [3:0] SEL_GLOBAL = 4'hF;

  localparam logic [3:0] FLD_FREQ  = 4'd0;
  localparam logic [3:0] FLD_RATE  = 4'd1;
  localparam logic [3:0] FLD_GAIN  = 4'd2;
  localparam logic [3:0] FLD_CASEL = 4'd3;

  localparam logic [3:0] FLD_NOISE = 4'd0;
  localparam logic [3:0] FLD_CTRL  = 4'd1;

  localparam int CA_SEL_MAX = 35;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_APPLY
  } state_e;

  typedef struct packed {
    logic [31:0] freq;
    logic [31:0] rate;
    logic [15:0] gain;
    logic [5:0]  ca_sel;
  } sat_cfg_t;

  // A write is legal when it targets an existing satellite field (0..3) or a
  // defined global field, and a C/A select value is within the PRN table.
  function automatic logic write_legal(input logic [7:0]  addr,
                                       input logic [31:0] data,
                                       input int          nsat);
    logic ok;
    ok = 1'b0;
    if (addr[7:4] == SEL_GLOBAL) begin
      ok = (addr[3:0] == FLD_NOISE) || (addr[3:0] == FLD_CTRL);
    end else if (int'(addr[7:4]) < nsat) begin
      ok = (addr[3:0] <= FLD_CASEL);
      if ((addr[3:0] == FLD_CASEL) && (data > 32'(CA_SEL_MAX))) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/gps_emu_scenario_ctrl_epoch_timer.sv
// epoch_timer: 1 ms C/A code epoch counter for the scenario controller.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_run         : active run flag; counter held at 0 while low
//   i_restart     : synchronous restart to 0 (used when run is switched on)
//   o_wrap        : high during the last count of an epoch (combinational)
//   o_pulse       : registered one-cycle pulse following each wrap
module epoch_timer #(
  parameter int EPOCH_CLKS = 102300
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_run,
  input  logic i_restart,
  output logic o_wrap,
  output logic o_pulse
);

  localparam int CW = (EPOCH_CLKS > 1) ? $clog2(EPOCH_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(EPOCH_CLKS - 1);

  logic [CW-1:0] r_count;
  logic          r_pulse;
  logic          w_wrap;

  assign w_wrap  = i_run && !i_restart && (r_count == LAST);
  assign o_wrap  = w_wrap;
  assign o_pulse = r_pulse;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_wrap;
      if (i_restart || !i_run || w_wrap) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gps_emu_scenario_ctrl.sv
// gps_emu_scenario_ctrl: host-programmable scenario controller for the GPS
// emulator. Host writes land in shadow registers; a commit copies every
// shadow register to the active outputs in one cycle (on a code epoch when
// running). Active Doppler is ramped by a per-satellite rate each epoch.
// Ports:
//   clk, rstn               : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready     : host write handshake
//   cfg_addr, cfg_data      : [7:4] target (satellite or 0xF global), [3:0] field
//   commit                  : request shadow -> active transfer
//   pending                 : commit armed but not yet applied
//   cfg_err                 : one-cycle pulse after an illegal write
//   emu_enable              : 1 holds emulator code phase at chip 0
//   freq/gain/ca_sel        : active per-satellite outputs
//   noise_gain              : active noise gain
//   epoch_pulse             : one-cycle pulse per code epoch while running
module gps_emu_scenario_ctrl
  import gps_emu_pkg::*;
#(
  parameter int NSAT       = 4,
  parameter int EPOCH_CLKS = 102300
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [7:0]           cfg_addr,
  input  logic [31:0]          cfg_data,
  input  logic                 commit,
  output logic                 pending,
  output logic                 cfg_err,
  output logic                 emu_enable,
  output logic [NSAT-1:0][31:0] freq,
  output logic [NSAT-1:0][15:0] gain,
  output logic [NSAT-1:0][5:0]  ca_sel,
  output logic [15:0]          noise_gain,
  output logic                 epoch_pulse
);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_cfg_ready;
  logic        r_pending;
  logic        r_cfg_err;
  logic        r_emu_enable;

  sat_cfg_t    r_shadow [NSAT];
  sat_cfg_t    r_active [NSAT];
  logic [15:0] r_sh_noise;
  logic [15:0] r_act_noise;
  logic        r_sh_run;
  logic        r_run;

  logic        w_hs;
  logic        w_legal;
  logic        w_apply;
  logic        w_restart;
  logic        w_wrap;
  logic        w_epoch_pulse;

  assign w_hs      = cfg_valid && r_cfg_ready;
  assign w_legal   = write_legal(cfg_addr, cfg_data, NSAT);
  assign w_apply   = (r_state == ST_APPLY);
  // Only a stopped->running transition realigns the epoch counter; an apply
  // while already running must not stretch the current epoch.
  assign w_restart = w_apply && r_sh_run && !r_run;

  epoch_timer #(
    .EPOCH_CLKS(EPOCH_CLKS)
  ) u_epoch_timer (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_run     (r_run),
    .i_restart (w_restart),
    .o_wrap    (w_wrap),
    .o_pulse   (w_epoch_pulse)
  );

  // While armed and running, the apply is deferred to the epoch wrap so the
  // new scenario starts exactly on a code epoch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (commit) w_state_next = ST_ARMED;
      ST_ARMED: if (!r_run || w_wrap) w_state_next = ST_APPLY;
      ST_APPLY: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_cfg_ready <= 1'b1;
      r_pending   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cfg_ready <= (w_state_next == ST_IDLE);
      r_pending   <= (w_state_next != ST_IDLE);
    end
  end

  // Shadow registers only change on an accepted legal write; cfg_ready is
  // low outside IDLE, which freezes them while a commit is in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < NSAT; s++) begin
        r_shadow[s] <= '0;
      end
      r_sh_noise <= '0;
      r_sh_run   <= 1'b0;
    end else if (w_hs && w_legal) begin
      for (int s = 0; s < NSAT; s++) begin
        if (cfg_addr[7:4] == 4'(s)) begin
          case (cfg_addr[3:0])
            FLD_FREQ:  r_shadow[s].freq   <= cfg_data;
            FLD_RATE:  r_shadow[s].rate   <= cfg_data;
            FLD_GAIN:  r_shadow[s].gain   <= cfg_data[15:0];
            FLD_CASEL: r_shadow[s].ca_sel <= cfg_data[5:0];
            default:   ;
          endcase
        end
      end
      if (cfg_addr[7:4] == SEL_GLOBAL) begin
        case (cfg_addr[3:0])
          FLD_NOISE: r_sh_noise <= cfg_data[15:0];
          FLD_CTRL:  r_sh_run   <= cfg_data[0];
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_hs && !w_legal;
    end
  end

  // Active registers: a commit overwrites everything at once. The ramp step
  // is skipped on the wrap that triggers an apply, so a commit epoch loads
  // freq straight from shadow without an extra rate step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < NSAT; s++) begin
        r_active[s] <= '0;
      end
      r_act_noise  <= '0;
      r_run        <= 1'b0;
      r_emu_enable <= 1'b1;
    end else if (w_apply) begin
      for (int s = 0; s < NSAT; s++) begin
        r_active[s] <= r_shadow[s];
      end
      r_act_noise  <= r_sh_noise;
      r_run        <= r_sh_run;
      r_emu_enable <= !r_sh_run;
    end else if (w_wrap && (r_state != ST_ARMED)) begin
      for (int s = 0; s < NSAT; s++) begin
        r_active[s].freq <= r_active[s].freq + r_active[s].rate;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NSAT; s++) begin
      freq[s]   = r_active[s].freq;
      gain[s]   = r_active[s].gain;
      ca_sel[s] = r_active[s].ca_sel;
    end
  end

  assign cfg_ready   = r_cfg_ready;
  assign pending     = r_pending;
  assign cfg_err     = r_cfg_err;
  assign emu_enable  = r_emu_enable;
  assign noise_gain  = r_act_noise;
  assign epoch_pulse = w_epoch_pulse;

endmodule

// File: tb/tb_gps_emu_scenario_ctrl.sv
// Self-checking bench for gps_emu_scenario_ctrl with a short epoch.
// The reference model holds shadow/active values as plain arrays and applies
// the address-map, commit and ramp rules directly; epoch boundaries are
// derived from a free-running cycle count relative to the run start.
module tb_gps_emu_scenario_ctrl;

  localparam int NSAT  = 4;
  localparam int EPOCH = 40;

  logic                  clk       = 1'b0;
  logic                  rstn      = 1'b1;
  logic                  cfg_valid = 1'b0;
  logic                  commit    = 1'b0;
  logic [7:0]            cfg_addr  = '0;
  logic [31:0]           cfg_data  = '0;
  logic                  cfg_ready;
  logic                  pending;
  logic                  cfg_err;
  logic                  emu_enable;
  logic                  epoch_pulse;
  logic [NSAT-1:0][31:0] freq;
  logic [NSAT-1:0][15:0] gain;
  logic [NSAT-1:0][5:0]  ca_sel;
  logic [15:0]           noise_gain;

  int checks   = 0;
  int errors   = 0;
  int cycle    = 0;
  int runStart = 0;

  logic [31:0] mShFreq [NSAT];
  logic [31:0] mShRate [NSAT];
  logic [15:0] mShGain [NSAT];
  logic [5:0]  mShCa   [NSAT];
  logic [31:0] mActFreq[NSAT];
  logic [31:0] mActRate[NSAT];
  logic [15:0] mActGain[NSAT];
  logic [5:0]  mActCa  [NSAT];
  logic [15:0] mShNoise, mActNoise;
  logic        mShRun, mRun;

  gps_emu_scenario_ctrl #(
    .NSAT(NSAT),
    .EPOCH_CLKS(EPOCH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .commit     (commit),
    .pending    (pending),
    .cfg_err    (cfg_err),
    .emu_enable (emu_enable),
    .freq       (freq),
    .gain       (gain),
    .ca_sel     (ca_sel),
    .noise_gain (noise_gain),
    .epoch_pulse(epoch_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int s = 0; s < NSAT; s++) begin
      mShFreq[s] = '0; mShRate[s] = '0; mShGain[s] = '0; mShCa[s] = '0;
      mActFreq[s] = '0; mActRate[s] = '0; mActGain[s] = '0; mActCa[s] = '0;
    end
    mShNoise = '0; mActNoise = '0; mShRun = 1'b0; mRun = 1'b0;
  endfunction

  function automatic bit modelWrite(input logic [7:0] a, input logic [31:0] d);
    int sel;
    int fld;
    sel = int'(a[7:4]);
    fld = int'(a[3:0]);
    if (sel == 15) begin
      if (fld == 0) begin mShNoise = d[15:0]; return 1'b1; end
      if (fld == 1) begin mShRun = d[0]; return 1'b1; end
      return 1'b0;
    end
    if (sel >= NSAT) return 1'b0;
    case (fld)
      0: mShFreq[sel] = d;
      1: mShRate[sel] = d;
      2: mShGain[sel] = d[15:0];
      3: begin
        if (d > 32'd35) return 1'b0;
        mShCa[sel] = d[5:0];
      end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic void modelApply();
    for (int s = 0; s < NSAT; s++) begin
      mActFreq[s] = mShFreq[s]; mActRate[s] = mShRate[s];
      mActGain[s] = mShGain[s]; mActCa[s]   = mShCa[s];
    end
    mActNoise = mShNoise;
    mRun      = mShRun;
  endfunction

  function automatic void modelRamp();
    for (int s = 0; s < NSAT; s++) mActFreq[s] = mActFreq[s] + mActRate[s];
  endfunction

  task automatic checkAll(input string tag);
    for (int s = 0; s < NSAT; s++) begin
      checkOutput($sformatf("%s_freq%0d", tag, s), freq[s], mActFreq[s]);
      checkOutput($sformatf("%s_gain%0d", tag, s), gain[s], mActGain[s]);
      checkOutput($sformatf("%s_ca%0d", tag, s), ca_sel[s], mActCa[s]);
    end
    checkOutput({tag, "_noise"}, noise_gain, mActNoise);
    checkOutput({tag, "_enable"}, emu_enable, !mRun);
  endtask

  // One host write: wait (bounded) for ready, complete the handshake, then
  // confirm the error pulse matches the model's legality decision.
  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d);
    bit legal;
    int n;
    cfg_addr  = a;
    cfg_data  = d;
    cfg_valid = 1'b1;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 4 * EPOCH) begin
      tick(1);
      n++;
    end
    checkOutput($sformatf("wr_ready_%02h", a), cfg_ready, 1);
    tick(1);
    cfg_valid = 1'b0;
    legal = modelWrite(a, d);
    checkOutput($sformatf("wr_err_%02h", a), cfg_err, !legal);
  endtask

  task automatic commitStopped(input string tag, input bit withWrite,
                               input logic [7:0] a, input logic [31:0] d);
    bit legal;
    commit = 1'b1;
    if (withWrite) begin
      cfg_addr  = a;
      cfg_data  = d;
      cfg_valid = 1'b1;
    end
    tick(1);
    commit    = 1'b0;
    cfg_valid = 1'b0;
    if (withWrite) legal = modelWrite(a, d);
    checkOutput({tag, "_pend1"}, pending, 1);
    checkOutput({tag, "_rdy0"}, cfg_ready, 0);
    tick(1);
    checkAll({tag, "_early"});
    tick(1);
    modelApply();
    checkOutput({tag, "_pend0"}, pending, 0);
    checkAll(tag);
  endtask

  task automatic waitPhase(input int ph);
    int g;
    g = 0;
    while (((cycle - runStart) % EPOCH) != ph && g < 2 * EPOCH) begin
      tick(1);
      g++;
    end
  endtask

  initial begin
    bit seen;
    bit held;
    modelReset();

    // Reset values
    #1 rstn = 1'b0;
    #1;
    checkOutput("rst_ready", cfg_ready, 1);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_err", cfg_err, 0);
    checkOutput("rst_pulse", epoch_pulse, 0);
    checkAll("rst");
    #10 rstn = 1'b1;
    tick(2);

    // First stopped commit, including exact values from the plan
    $display("[TB] stopped commit");
    applyStimulus(8'h00, 32'h0100_0000);
    applyStimulus(8'h02, 32'h0000_4000);
    applyStimulus(8'h03, 32'd4);
    applyStimulus(8'h30, $urandom);
    applyStimulus(8'h32, $urandom);
    applyStimulus(8'h33, $urandom_range(35, 0));
    applyStimulus(8'hF0, $urandom);
    commitStopped("c1", 1'b0, 8'h00, 32'h0);
    checkOutput("c1_sat0freq", freq[0], 32'h0100_0000);
    checkOutput("c1_sat0gain", gain[0], 32'h4000);
    checkOutput("c1_sat0ca", ca_sel[0], 32'd4);

    // Illegal writes; a write in the commit cycle joins that commit
    $display("[TB] illegal writes");
    applyStimulus(8'h03, 32'd36);
    tick(1);
    checkOutput("err_fall", cfg_err, 0);
    applyStimulus(8'h50, $urandom);
    applyStimulus(8'hF2, 32'h1);
    applyStimulus(8'h14, 32'h5);
    commitStopped("c_ill", 1'b1, 8'h23, 32'($urandom_range(35, 0)));
    checkOutput("ill_ca0", ca_sel[0], 32'd4);

    // Start running with a wrapping Doppler ramp
    $display("[TB] run start");
    applyStimulus(8'h10, 32'hFFFF_FFC0);
    applyStimulus(8'h11, 32'd100);
    applyStimulus(8'h31, $urandom);
    applyStimulus(8'hF1, 32'h1);
    commitStopped("c_run", 1'b0, 8'h00, 32'h0);
    runStart = cycle;
    checkOutput("run_enable0", emu_enable, 0);
    seen = 1'b0;
    for (int i = 1; i < EPOCH; i++) begin
      tick(1);
      if (epoch_pulse !== 1'b0) seen = 1'b1;
    end
    checkOutput("ep1_no_early", seen, 0);
    tick(1);
    checkOutput("ep1_pulse", epoch_pulse, 1);
    modelRamp();
    checkAll("ep1");
    checkOutput("ep1_sat1", freq[1], 32'h0000_0024);
    tick(1);
    checkOutput("ep1_pulse_fall", epoch_pulse, 0);
    tick(EPOCH - 1);
    checkOutput("ep2_pulse", epoch_pulse, 1);
    modelRamp();
    checkAll("ep2");
    checkOutput("ep2_sat1", freq[1], 32'h0000_0088);

    // Mid-epoch commit while running; a held write waits for IDLE
    $display("[TB] mid-epoch commit");
    tick(5);
    applyStimulus(8'h22, 32'h1234);
    commit = 1'b1;
    tick(1);
    commit    = 1'b0;
    cfg_addr  = 8'h23;
    cfg_data  = 32'($urandom_range(35, 0));
    cfg_valid = 1'b1;
    held = 1'b1;
    while (((cycle - runStart) % EPOCH) != 0 && (cycle - runStart) < 4 * EPOCH) begin
      if (pending !== 1'b1 || cfg_ready !== 1'b0 || gain[2] !== mActGain[2]) held = 1'b0;
      tick(1);
    end
    checkOutput("armed_hold", held, 1);
    checkOutput("cwrap_pulse", epoch_pulse, 1);
    checkOutput("cwrap_pend", pending, 1);
    checkAll("cwrap");
    tick(1);
    modelApply();
    checkAll("capply");
    checkOutput("capply_gain2", gain[2], 32'h1234);
    checkOutput("capply_pend", pending, 0);
    checkOutput("capply_rdy", cfg_ready, 1);
    tick(1);
    cfg_valid = 1'b0;
    checkOutput("held_wr_err", cfg_err, !modelWrite(cfg_addr, cfg_data));

    // Commit issued on the wrap cycle waits a full epoch
    $display("[TB] commit on wrap");
    waitPhase(EPOCH - 1);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    modelRamp();
    checkOutput("cw_pulse", epoch_pulse, 1);
    checkOutput("cw_pend", pending, 1);
    checkAll("cw_ramp");
    tick(EPOCH);
    checkOutput("cw2_pulse", epoch_pulse, 1);
    checkAll("cw_noramp");
    tick(1);
    modelApply();
    checkAll("cw_apply");

    // Stop running
    $display("[TB] run stop");
    applyStimulus(8'hF1, 32'h0);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    waitPhase(0);
    tick(1);
    modelApply();
    checkAll("stop");
    seen = 1'b0;
    for (int i = 0; i < 2 * EPOCH; i++) begin
      tick(1);
      if (epoch_pulse !== 1'b0) seen = 1'b1;
    end
    checkOutput("stop_no_pulse", seen, 0);
    checkAll("stop_hold");

    // Asynchronous reset while ARMED discards the commit
    $display("[TB] reset while armed");
    applyStimulus(8'h02, $urandom);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    checkOutput("rarm_pend1", pending, 1);
    #2 rstn = 1'b0;
    #1;
    modelReset();
    checkOutput("rarm_pend0", pending, 0);
    checkOutput("rarm_rdy", cfg_ready, 1);
    checkOutput("rarm_err", cfg_err, 0);
    checkOutput("rarm_pulse", epoch_pulse, 0);
    checkAll("rarm");
    #3 rstn = 1'b1;
    tick(4);
    checkOutput("rarm_after_pend", pending, 0);
    checkAll("rarm_after");
    commitStopped("post_rst", 1'b0, 8'h00, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gps_emu_scenario_ctrl.md
# gps_emu_scenario_ctrl

Scenario controller for the GPS emulator. Takes host register writes into per-satellite shadow registers, then commits them atomically to the active Doppler/gain/C/A-select/noise-gain outputs that drive the emulator's channel inputs. When running, commits land only on a 1 ms C/A code epoch. The block also applies a per-satellite linear Doppler ramp once per epoch and owns the emulator's code-phase `enable` line.

## Interface
Parameters:
- `NSAT`, 4: number of satellite channels; must be ≤ 15.
- `EPOCH_CLKS`, 102300: clk cycles per 1 ms code epoch.

Ports:
- `clk` in 1: 102.3 MHz system clock.
- `rstn` in 1: reset. Asynchronous assert, active-low.
- `cfg_valid` in 1: host write request.
- `cfg_ready` out 1: write accepted when `cfg_valid && cfg_ready`.
- `cfg_addr` in 8: `[7:4]` selects the target (satellite index, or 0xF for global); `[3:0]` selects the field.
- `cfg_data` in 32: write data.
- `commit` in 1: single-cycle request to transfer shadow registers to active registers.
- `pending` out 1: a commit is armed and not yet applied.
- `cfg_err` out 1: one-cycle pulse on an illegal write.
- `emu_enable` out 1: drives the emulator's `enable` input. 1 holds the code phase at chip 0.
- `freq` out 32 × NSAT: active Doppler per satellite.
- `gain` out 16 × NSAT: active gain per satellite.
- `ca_sel` out 6 × NSAT: active C/A select (0–35).
- `noise_gain` out 16: active noise gain.
- `epoch_pulse` out 1: one-cycle pulse at each code epoch while running.

## Operation
Address map:
- Satellite s (`s < NSAT`):
  - field 0: freq
  - field 1: rate, signed 32-bit Doppler step per epoch
  - field 2: gain, `data[15:0]`
  - field 3: ca_sel, `data[5:0]`
- Global (0xF):
  - field 0: noise_gain, `data[15:0]`
  - field 1: ctrl, bit0 = run
- Illegal writes: any other address, or ca_sel data > 35. The write is accepted (handshake completes), shadow is unchanged, and `cfg_err` pulses the following cycle.

FSM states:
- IDLE:
  - `cfg_ready` = 1.
  - On `commit`, go to ARMED. A write accepted in the same cycle as `commit` is included in that commit.
- ARMED:
  - `cfg_ready` = 0 and `pending` = 1; the shadow registers are frozen.
  - `commit` is ignored here.
  - If active run = 0, go to APPLY on the next cycle.
  - If active run = 1, go to APPLY on the cycle where the epoch counter reaches `EPOCH_CLKS-1`.
- APPLY (one cycle):
  - Copy all shadow registers to the active registers simultaneously, including run.
  - Return to IDLE.

Run control:
- run 0→1 applied: `emu_enable` drops to 0 and the epoch counter restarts at 0 in the same cycle, so the counter is aligned with emulator chip 0.
- run 1→0 applied: `emu_enable` = 1 and the epoch counter is held at 0.

Epoch and Doppler ramp:
- The epoch counter counts 0..`EPOCH_CLKS-1` while run = 1.
- `epoch_pulse` fires on the wrap cycle.
- On each epoch while running and not applying a commit: `freq[s] += rate[s]`, modulo 2^32 (wraps, does not saturate).
- On a commit epoch, freq loads from shadow and no ramp step is added in that epoch.

## Timing
- Reset values:
  - `emu_enable` = 1, `cfg_ready` = 1.
  - `pending`, `cfg_err`, `epoch_pulse` = 0.
  - All active and shadow registers = 0; run = 0; state IDLE; epoch counter = 0.
- All outputs are registered.
- Latencies:
  - Shadow register updates 1 cycle after the handshake.
  - `pending` rises 1 cycle after `commit`.
  - Active outputs change 1 cycle after the APPLY decision: 2 cycles after `commit` when stopped, or the cycle after the epoch wrap when running.
  - `pending` falls together with the active-output update.
- Reset mid-ARMED: the commit is discarded and all state returns to reset values.
- `commit` and epoch wrap in the same cycle while running: this is not that epoch's commit. The ramp applies now and the commit applies at the next epoch.

## Structure
- Package `gps_emu_pkg`:
  - field-offset and global-index constants
  - `CA_SEL_MAX` = 35
  - FSM state enum
  - a `sat_cfg_t` struct {freq, rate, gain, ca_sel}
- Sub-module `epoch_timer`: counter with synchronous restart/hold and wrap pulse.
- Shadow and active arrays are `sat_cfg_t [NSAT]`.

## Test plan
- Reset, then write sat0 freq=0x0100_0000, gain=0x4000, ca_sel=4 and commit while stopped → the outputs show those values exactly 2 cycles after `commit`; `emu_enable` = 1.
- Write ctrl.run=1 and commit → `emu_enable` = 0; first `epoch_pulse` exactly `EPOCH_CLKS` cycles later.
- Running with sat1 rate=+100 and freq=0xFFFF_FFC0 → after 1 epoch freq = 0x0000_0024 (wrap); after 2 epochs freq = 0x0000_0088.
- While running, write sat2 gain=0x1234 and commit mid-epoch → `cfg_ready` = 0 and `pending` = 1 until the wrap; gain updates on the cycle after the wrap; a `cfg_valid` held during ARMED completes only after return to IDLE.
- Write ca_sel=36, and a write to addr 0x5? with NSAT=4 → each accepted, `cfg_err` pulses, shadow unchanged (confirmed by a later commit).
- Assert `rstn` low while ARMED → all outputs at reset values immediately (asynchronous); no apply after release.
